pll_rst_seq: RTL and testbench
==============================

# pll_rst_seq

Reset sequencer downstream of the ULX3S PLL clock generator. It consumes the PLL `locked` flag, which is asynchronous to this block's clock, and filters it for stability. After a hold period it releases a vector of active-low domain resets in staggered order, so that fabric stages (video, memory, I/O) leave reset in a fixed sequence. It re-asserts all resets on lock loss or on a software request, and keeps a saturating lock-loss counter for debug.

## Interface
- `LOCK_FILT`, 1024: cycles `locked` must stay continuously high before the hold phase starts (≥1).
- `RST_HOLD`, 256: cycles all resets stay asserted after the filter passes (≥1).
- `NRST`, 4: number of reset outputs (≥1).
- `STAGGER`, 16: cycles between consecutive reset releases (≥1).
- `CNT_W`, 8: width of the lock-loss counter.
- `clk`  in  1: block clock; this is one PLL output, normally the 25 MHz output.
- `rst_n`  in  1: reset; synchronous, active-low.
- `locked`  in  1: raw PLL lock flag, asynchronous to `clk`.
- `req`  in  1: one-cycle software re-sequence request.
- `rst_o_n`  out  NRST: domain resets, active-low; bit 0 is released first.
- `ready`  out  1: high while all resets are released (state RUN).
- `loss_cnt`  out  CNT_W: saturating count of lock-loss events.

## Operation
- `locked` passes through a 2-FF synchronizer, giving `lk_s`. Both flops clear on `rst_n`=0.
- States: IDLE, FILTER, HOLD, RELEASE, RUN. A single counter `cnt` is shared and sized to max(LOCK_FILT, RST_HOLD, STAGGER).
- Transitions in IDLE:
  - IDLE→FILTER when `lk_s`=1; `cnt`←0.
- Transitions in FILTER:
  - `lk_s`=0 → IDLE. This is a glitch and is not counted.
  - Otherwise `cnt`++.
  - When `cnt`=LOCK_FILT-1 → HOLD, `cnt`←0.
- Transitions in HOLD:
  - `cnt`++.
  - When `cnt`=RST_HOLD-1 → RELEASE, `cnt`←0, `rst_o_n[0]`←1 on the same edge.
- Transitions in RELEASE:
  - `cnt`++.
  - When `cnt`=STAGGER-1, set the next `rst_o_n` bit and `cnt`←0.
  - On the edge that sets bit NRST-1 → RUN and `ready`←1.
  - If NRST=1, HOLD goes directly to RUN and sets both bit 0 and `ready`.
- Lock loss (`lk_s`=0 in HOLD, RELEASE or RUN):
  - Next edge: → IDLE, `rst_o_n`←0, `ready`←0.
  - `loss_cnt`++ only if leaving RELEASE or RUN, i.e. at least one reset was released. It saturates at 2^CNT_W-1.
- `req`=1 in RUN: → HOLD, `rst_o_n`←0, `ready`←0, `cnt`←0. Not counted. `req` is ignored in all other states.
- Simultaneous `lk_s`=0 and `req` in RUN: lock loss wins → IDLE, and the event is counted.
- `rst_n`=0 (any state, including mid-sequence), on the next edge:
  - state←IDLE, `cnt`←0
  - `rst_o_n`←all 0, `ready`←0
  - `loss_cnt`←0

## Timing
- Reset values: `rst_o_n`=0, `ready`=0, `loss_cnt`=0, state IDLE.
- All outputs are registered; there is no combinational path from any input to any output.
- Let edge 0 be the first edge that samples `locked`=1 into the synchronizer. With `locked` held high:
  - `rst_o_n[0]` rises after edge 2+LOCK_FILT+RST_HOLD.
  - `rst_o_n[i]` rises STAGGER·i edges later.
  - `ready` rises together with `rst_o_n[NRST-1]`.
- Lock-loss latency: `locked` falling to `rst_o_n`=0 takes 3 edges (2 synchronizer edges + 1 state edge).
- `req` to `rst_o_n`=0: 1 edge. Re-release follows RST_HOLD edges later.
- `loss_cnt` updates on the same edge as the resets assert.

## Structure
- Package `pll_rst_seq_pkg`:
  - state enum `seq_state_t` (IDLE, FILTER, HOLD, RELEASE, RUN)
  - width helper for `cnt`: clog2 of the maximum of the three length parameters.
- Sub-module `ff_sync`:
  - generic N-stage (default 2) single-bit synchronizer with synchronous active-low clear.
  - Instantiated once for `locked`.
- The top module holds the FSM, the shared counter, the reset shift vector and `loss_cnt`.

## Test plan
Parameters for all scenarios: LOCK_FILT=8, RST_HOLD=4, NRST=4, STAGGER=2, CNT_W=2.
1. Clean lock: `locked` rises at edge 0 and stays high → `rst_o_n[0..3]` rise after edges 14/16/18/20; `ready`=1 after edge 20; `loss_cnt`=0.
2. Filter glitch: `locked` high for 5 cycles, low for 1, then high → no reset released; `rst_o_n[0]` rises 14 edges after the second rising sample; `loss_cnt`=0.
3. Loss in RUN: drop `locked` → all `rst_o_n`=0 and `ready`=0 3 edges later; `loss_cnt`=1. Repeat 4 times → `loss_cnt` saturates at 3.
4. Loss during HOLD → state IDLE, `loss_cnt` unchanged. Loss after `rst_o_n[0]` only has risen → `loss_cnt`+1.
5. `req` pulse in RUN → `rst_o_n`=0 next edge; `rst_o_n[0]` back high 4 edges later; `loss_cnt` unchanged. `req` together with `locked` loss → counted once. `req` in FILTER → no effect.
6. `rst_n`=0 mid-RELEASE (`rst_o_n`=0011) → next edge `rst_o_n`=0000, `ready`=0, `loss_cnt`=0. After `rst_n`=1 with `locked` steady high, the full sequence restarts per scenario 1.

Source files
------------

// File: rtl/pll_rst_seq_pkg.sv
// Shared types and sizing helpers for the PLL reset sequencer.
package pll_rst_seq_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FILTER  = 3'd1,
        HOLD    = 3'd2,
        RELEASE = 3'd3,
        RUN     = 3'd4
    } seq_state_t;

    // One counter covers filter, hold and stagger phases, so size it for the longest.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/ff_sync.sv
// N-stage single-bit synchronizer with synchronous active-low clear.
module ff_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_p;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_p <= '0;
        end else begin
            sync_p[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                sync_p[i] <= sync_p[i-1];
            end
        end
    end

    assign q = sync_p[STAGES-1];

endmodule

// File: rtl/pll_rst_seq.sv
// Filters PLL lock, then releases active-low domain resets in staggered order;
// re-asserts them on lock loss or software request and counts lock losses.
module pll_rst_seq
    import pll_rst_seq_pkg::*;
#(
    parameter int LOCK_FILT = 1024,
    parameter int RST_HOLD  = 256,
    parameter int NRST      = 4,
    parameter int STAGGER   = 16,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             locked,
    input  logic             req,
    output logic [NRST-1:0]  rst_o_n,
    output logic             ready,
    output logic [CNT_W-1:0] loss_cnt
);

    localparam int CW = cnt_width(LOCK_FILT, RST_HOLD, STAGGER);
    localparam logic [CW-1:0]   FILT_LAST = CW'(LOCK_FILT - 1);
    localparam logic [CW-1:0]   HOLD_LAST = CW'(RST_HOLD - 1);
    localparam logic [CW-1:0]   STAG_LAST = CW'(STAGGER - 1);
    localparam logic [NRST-1:0] ALL_REL   = '1;

    seq_state_t       state, state_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic [NRST-1:0]  rst_vec, rst_nx, rel_next;
    logic             ready_q, ready_nx;
    logic [CNT_W-1:0] loss_q, loss_nx;
    logic             lk_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    ff_sync #(.STAGES(2)) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (locked),
        .q     (lk_s)
    );

    // Bit 0 is released first; each release shifts one more 1 in from the bottom.
    assign rel_next = (rst_vec << 1) | NRST'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            rst_vec <= '0;
            ready_q <= 1'b0;
            loss_q  <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            rst_vec <= rst_nx;
            ready_q <= ready_nx;
            loss_q  <= loss_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            IDLE: begin
                if (lk_s) begin
                    state_nx = FILTER;
                    cnt_nx   = '0;
                end
            end
            FILTER: begin
                if (!lk_s) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (cnt == FILT_LAST) begin
                    state_nx = HOLD;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            HOLD: begin
                if (!lk_s) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (cnt == HOLD_LAST) begin
                    state_nx = (rel_next == ALL_REL) ? RUN : RELEASE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            RELEASE: begin
                if (!lk_s) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (cnt == STAG_LAST) begin
                    if (rel_next == ALL_REL) state_nx = RUN;
                    cnt_nx = '0;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            RUN: begin
                // Lock loss takes priority over a simultaneous software request.
                if (!lk_s) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (req) begin
                    state_nx = HOLD;
                    cnt_nx   = '0;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    always_comb begin
        rst_nx   = rst_vec;
        loss_nx  = loss_q;
        ready_nx = (state_nx == RUN);
        unique case (state)
            HOLD: begin
                if (lk_s && cnt == HOLD_LAST) rst_nx = rel_next;
                else                          rst_nx = '0;
            end
            RELEASE: begin
                if (!lk_s) begin
                    rst_nx  = '0;
                    loss_nx = sat_inc(loss_q);
                end else if (cnt == STAG_LAST) begin
                    rst_nx = rel_next;
                end
            end
            RUN: begin
                if (!lk_s) begin
                    rst_nx  = '0;
                    loss_nx = sat_inc(loss_q);
                end else if (req) begin
                    rst_nx = '0;
                end
            end
            default: rst_nx = '0;
        endcase
    end

    assign rst_o_n  = rst_vec;
    assign ready    = ready_q;
    assign loss_cnt = loss_q;

endmodule

// File: tb/tb_pll_rst_seq.sv
// Directed + randomized bench for pll_rst_seq with a timeline-based reference model.
module tb_pll_rst_seq;

    localparam int LF = 8;
    localparam int RH = 4;
    localparam int NR = 4;
    localparam int SG = 2;
    localparam int CW = 2;
    localparam int LOSS_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          locked = 1'b0;
    logic          req = 1'b0;
    logic [NR-1:0] rst_o_n;
    logic          ready;
    logic [CW-1:0] loss_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Model: a sequence is a timeline anchored at the edge where bit 0 releases.
    int edge_n   = 0;
    bit m_active = 1'b0;
    int m_t0     = 0;
    int m_loss   = 0;
    bit m_s1     = 1'b0;
    bit m_s2     = 1'b0;

    pll_rst_seq #(
        .LOCK_FILT (LF),
        .RST_HOLD  (RH),
        .NRST      (NR),
        .STAGGER   (SG),
        .CNT_W     (CW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .locked   (locked),
        .req      (req),
        .rst_o_n  (rst_o_n),
        .ready    (ready),
        .loss_cnt (loss_cnt)
    );

    always #5 clk = ~clk;

    function automatic int rel_at(input int n);
        int r;
        if (!m_active || n < m_t0) return 0;
        r = (n - m_t0) / SG + 1;
        return (r > NR) ? NR : r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s at edge %0d: observed=%0h expected=%0h", tag, edge_n, obs, exp);
        end
    endtask

    task automatic step(input bit r, input bit l, input bit q);
        int  kprev;
        int  k;
        bit  lk;
        rst_n  = r;
        locked = l;
        req    = q;
        @(posedge clk);
        if (!r) begin
            m_active = 1'b0;
            m_loss   = 0;
            m_s1     = 1'b0;
            m_s2     = 1'b0;
        end else begin
            kprev = rel_at(edge_n - 1);
            lk    = m_s2;
            if (!m_active) begin
                if (lk) begin
                    m_active = 1'b1;
                    m_t0     = edge_n + LF + RH;
                end
            end else if (!lk) begin
                m_active = 1'b0;
                if (kprev > 0 && m_loss < LOSS_MAX) m_loss++;
            end else if (q && kprev == NR) begin
                m_t0 = edge_n + RH;
            end
            m_s2 = m_s1;
            m_s1 = l;
        end
        k = rel_at(edge_n);
        #1;
        chk("rst_o_n", 32'(rst_o_n), 32'((1 << k) - 1));
        chk("ready", 32'(ready), 32'(k == NR));
        chk("loss_cnt", 32'(loss_cnt), 32'(m_loss));
        edge_n++;
    endtask

    task automatic hold(input bit r, input bit l, input bit q, input int cycles);
        for (int i = 0; i < cycles; i++) step(r, l, q);
    endtask

    initial begin
        bit rl;
        bit ll;
        bit ql;

        hold(0, 0, 0, 3);
        chk("reset_rst", 32'(rst_o_n), 32'h0);
        chk("reset_ready", 32'(ready), 32'h0);

        // Clean lock: bit 0 after edge 14, all released after edge 20.
        hold(1, 1, 0, 14);
        chk("clean_pre", 32'(rst_o_n), 32'h0);
        step(1, 1, 0);
        chk("clean_bit0", 32'(rst_o_n), 32'h1);
        hold(1, 1, 0, 6);
        chk("clean_all", 32'(rst_o_n), 32'hF);
        chk("clean_ready", 32'(ready), 32'h1);

        // Repeated loss in RUN saturates the counter.
        for (int i = 0; i < 4; i++) begin
            hold(1, 0, 0, 2);
            chk("loss_lat_pre", 32'(rst_o_n), 32'hF);
            step(1, 0, 0);
            chk("loss_lat_rst", 32'(rst_o_n), 32'h0);
            hold(1, 0, 0, 1);
            hold(1, 1, 0, 22);
        end
        chk("loss_sat", 32'(loss_cnt), 32'(LOSS_MAX));

        // Filter glitch restarts the filter without counting.
        hold(0, 0, 0, 2);
        hold(1, 1, 0, 5);
        step(1, 0, 0);
        hold(1, 1, 0, 14);
        chk("glitch_pre", 32'(rst_o_n), 32'h0);
        step(1, 1, 0);
        chk("glitch_bit0", 32'(rst_o_n), 32'h1);
        hold(1, 1, 0, 8);

        // Loss during HOLD is not counted; loss after bit 0 is.
        hold(0, 0, 0, 2);
        hold(1, 1, 0, 11);
        hold(1, 0, 0, 3);
        chk("hold_loss", 32'(loss_cnt), 32'h0);
        hold(1, 1, 0, 13);
        hold(1, 0, 0, 2);
        chk("rel_loss_pre", 32'(rst_o_n), 32'h1);
        step(1, 0, 0);
        chk("rel_loss_cnt", 32'(loss_cnt), 32'h1);

        // Software request in RUN, request with loss, request in FILTER.
        hold(1, 1, 0, 22);
        chk("req_run", 32'(ready), 32'h1);
        step(1, 1, 1);
        chk("req_rst", 32'(rst_o_n), 32'h0);
        hold(1, 1, 0, 3);
        step(1, 1, 0);
        chk("req_rerel", 32'(rst_o_n), 32'h1);
        chk("req_nocount", 32'(loss_cnt), 32'h1);
        hold(1, 1, 0, 6);
        hold(1, 0, 0, 2);
        step(1, 0, 1);
        chk("req_loss_cnt", 32'(loss_cnt), 32'h2);
        hold(1, 1, 0, 5);
        step(1, 1, 1);
        hold(1, 1, 0, 20);

        // Reset mid-release, then full restart.
        hold(0, 0, 0, 2);
        hold(1, 1, 0, 17);
        chk("mid_rel", 32'(rst_o_n), 32'h3);
        step(0, 1, 0);
        chk("mid_rst", 32'(rst_o_n), 32'h0);
        chk("mid_loss", 32'(loss_cnt), 32'h0);
        hold(1, 1, 0, 14);
        step(1, 1, 0);
        chk("restart_bit0", 32'(rst_o_n), 32'h1);
        hold(1, 1, 0, 6);
        chk("restart_all", 32'(rst_o_n), 32'hF);

        // Randomized run with long lock stretches, occasional requests and resets.
        ll = 1'b1;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 24) == 0) ll = ~ll;
            ql = ($urandom_range(0, 7) == 0);
            rl = ($urandom_range(0, 199) != 0);
            step(rl, ll, ql);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
